// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module : tetris_pkg
// Brief  : Shared constants for the Tetris playfield video core: board
//          geometry, slot register offsets and the clear-FSM state type.
// Rev    : 1.0  initial release
// ============================================================================
package tetris_pkg;

   localparam int BOARD_COLS = 10;
   localparam int BOARD_ROWS = 20;
   localparam int CELL_PX    = 16;
   localparam int NUM_CELLS  = BOARD_COLS * BOARD_ROWS;

   // Register offsets, decoded from addr[4:0] when addr[13] is set
   localparam logic [4:0] REG_BYPASS   = 5'h00;
   localparam logic [4:0] REG_X0       = 5'h01;
   localparam logic [4:0] REG_Y0       = 5'h02;
   localparam logic [4:0] REG_FLASH    = 5'h03;
   localparam logic [4:0] REG_BLINK    = 5'h04;
   localparam logic [4:0] REG_CLEAR    = 5'h05;
   localparam logic [4:0] REG_PAL_BASE = 5'h10;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/tetris_cell_ram.sv
`default_nettype none
// ============================================================================
// Module : tetris_cell_ram
// Brief  : 200 x 4-bit playfield cell store, one write port and one
//          synchronous read port, no reset (contents set by the clear FSM).
// Ports  : clk            system clock
//          we/waddr/wdata write port (caller keeps waddr < NUM_CELLS)
//          raddr          read address (caller keeps raddr < NUM_CELLS)
//          rdata          registered read data
// Rev    : 1.0  initial release
// ============================================================================
module tetris_cell_ram
   import tetris_pkg::*;
(
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [3:0] wdata,
   input  logic [7:0] raddr,
   output logic [3:0] rdata
);

   logic [3:0] r_mem [0:NUM_CELLS-1];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
      rdata <= r_mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/tetris_board_core.sv
`default_nettype none
// ============================================================================
// Module : tetris_board_core
// Brief  : Renders the 10x20 Tetris playfield over the upstream video stream.
//          Empty cells (palette index KEY_COLOR) are transparent, cell edges
//          are drawn at half intensity, and flagged rows may blink.
// Ports  : clk, reset (sync, active-low)
//          x, y            frame counter position
//          cs, write, addr, wr_data   write-only video slot
//          si_rgb          upstream pixel, so_rgb  output pixel (2-cycle latency)
// Config : TETRIS_BOARD_FLASH_EN  builds row flash mask and blink logic
// Params : CD must be a multiple of 3 (three equal colour channels)
// Rev    : 1.0  initial release
// ============================================================================
module tetris_board_core
   import tetris_pkg::*;
#(
   parameter int CD        = 12,
   parameter int KEY_COLOR = 0
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic [10:0]   x,
   input  logic [10:0]   y,
   input  logic          cs,
   input  logic          write,
   input  logic [13:0]   addr,
   input  logic [31:0]   wr_data,
   input  logic [CD-1:0] si_rgb,
   output logic [CD-1:0] so_rgb
);

   localparam int          CH          = CD / 3;
   localparam logic [10:0] c_board_w   = 11'(BOARD_COLS * CELL_PX);
   localparam logic [10:0] c_board_h   = 11'(BOARD_ROWS * CELL_PX);
   localparam logic [7:0]  c_last_cell = 8'(NUM_CELLS - 1);
   localparam logic [7:0]  c_num_cells = 8'(NUM_CELLS);
   localparam logic [3:0]  c_key       = 4'(KEY_COLOR);

   // ---------------- slot decode ----------------
   logic w_we, w_reg_we, w_clr_cmd, w_cell_we;
   logic r_bypass;
   logic [10:0] r_x0, r_y0;
   logic [CD-1:0] r_palette [0:15];
   clr_state_t r_state;
   logic [7:0] r_clr_cnt;

   assign w_we      = cs & write;
   assign w_reg_we  = w_we & addr[13];
   assign w_clr_cmd = w_reg_we && (addr[4:0] == REG_CLEAR);
   // Slot cell writes lose to the clear sweep and to out-of-range indices
   assign w_cell_we = w_we && !addr[13] && (addr[7:0] < c_num_cells)
                      && (r_state == ST_IDLE);

   logic w_unused_bits;
   assign w_unused_bits = ^{addr, wr_data};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bypass <= 1'b0;
         r_x0     <= '0;
         r_y0     <= '0;
         for (int i = 0; i < 16; i++) begin
            r_palette[i] <= '0;
         end
      end else if (w_reg_we) begin
         case (addr[4:0])
            REG_BYPASS: r_bypass <= wr_data[0];
            REG_X0:     r_x0     <= wr_data[10:0];
            REG_Y0:     r_y0     <= wr_data[10:0];
            default: begin
               if (addr[4]) begin
                  r_palette[addr[3:0]] <= wr_data[CD-1:0];
               end
            end
         endcase
      end
   end

   // ---------------- clear FSM ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
      end else if (w_clr_cmd) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
      end else if (r_state == ST_CLEAR) begin
         if (r_clr_cnt == c_last_cell) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
         end else begin
            r_clr_cnt <= r_clr_cnt + 8'd1;
         end
      end
   end

   // ---------------- geometry (stage 1 inputs) ----------------
   logic [10:0] w_rel_x, w_rel_y;
   logic        w_in_board, w_edge;
   logic [4:0]  w_row;
   logic [3:0]  w_col;
   logic [7:0]  w_index, w_raddr;

   assign w_rel_x    = x - r_x0;
   assign w_rel_y    = y - r_y0;
   assign w_in_board = (x >= r_x0) && (w_rel_x < c_board_w) &&
                       (y >= r_y0) && (w_rel_y < c_board_h);
   assign w_row      = w_rel_y[8:4];
   assign w_col      = w_rel_x[7:4];
   assign w_index    = ({3'b000, w_row} << 3) + ({3'b000, w_row} << 1) + {4'b0000, w_col};
   // Off-board positions read cell 0 so the RAM never sees an index >= 200
   assign w_raddr    = w_in_board ? w_index : 8'd0;
   assign w_edge     = (w_rel_x[3:0] == 4'd0) || (w_rel_x[3:0] == 4'hF) ||
                       (w_rel_y[3:0] == 4'd0) || (w_rel_y[3:0] == 4'hF);

   logic       w_ram_we;
   logic [7:0] w_ram_waddr;
   logic [3:0] w_ram_wdata, w_cell_idx;

   assign w_ram_we    = (r_state == ST_CLEAR) | w_cell_we;
   assign w_ram_waddr = (r_state == ST_CLEAR) ? r_clr_cnt : addr[7:0];
   assign w_ram_wdata = (r_state == ST_CLEAR) ? 4'd0 : wr_data[3:0];

   tetris_cell_ram u_cell_ram (
      .clk   (clk),
      .we    (w_ram_we),
      .waddr (w_ram_waddr),
      .wdata (w_ram_wdata),
      .raddr (w_raddr),
      .rdata (w_cell_idx)
   );

   // ---------------- stage 1 registers ----------------
   logic          r1_in_board, r1_edge;
   logic [CD-1:0] r1_si;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r1_in_board <= 1'b0;
         r1_edge     <= 1'b0;
         r1_si       <= '0;
      end else begin
         r1_in_board <= w_in_board;
         r1_edge     <= w_edge;
         r1_si       <= si_rgb;
      end
   end

   // ---------------- row flash / blink ----------------
   logic w_hide;

`ifdef TETRIS_BOARD_FLASH_EN
   logic [19:0] r_flash_mask;
   logic [5:0]  r_blink_period, r_frame_cnt;
   logic        r_phase, r_tick, r1_flash;
   logic [31:0] w_mask_ext;

   // Zero-extended so any 5-bit row select stays in range
   assign w_mask_ext = {12'd0, r_flash_mask};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_flash_mask   <= '0;
         r_blink_period <= '0;
         r_frame_cnt    <= '0;
         r_phase        <= 1'b0;
         r_tick         <= 1'b0;
         r1_flash       <= 1'b0;
      end else begin
         r_tick   <= (x == 11'd0) && (y == 11'd0);
         r1_flash <= w_in_board & w_mask_ext[w_row];
         if (w_reg_we && (addr[4:0] == REG_FLASH)) begin
            r_flash_mask <= wr_data[19:0];
         end
         if (w_reg_we && (addr[4:0] == REG_BLINK)) begin
            r_blink_period <= wr_data[5:0];
            r_frame_cnt    <= '0;
            r_phase        <= 1'b0;
         end else if (r_tick) begin
            if (r_blink_period == 6'd0) begin
               r_frame_cnt <= '0;
               r_phase     <= 1'b0;
            end else if (r_frame_cnt == r_blink_period - 6'd1) begin
               r_frame_cnt <= '0;
               r_phase     <= ~r_phase;
            end else begin
               r_frame_cnt <= r_frame_cnt + 6'd1;
            end
         end
      end
   end

   assign w_hide = r1_flash & r_phase;
`else
   assign w_hide = 1'b0;
`endif

   // ---------------- stage 2: palette, dimming, output mux ----------------
   logic [CD-1:0] w_pal, w_dim, w_pix;

   assign w_pal = r_palette[w_cell_idx];

   for (genvar g = 0; g < 3; g++) begin : g_chan
      assign w_dim[g*CH +: CH] = w_pal[g*CH +: CH] >> 1;
   end

   always_comb begin
      w_pix = w_pal;
      if (!r1_in_board || r_bypass || (w_cell_idx == c_key) || w_hide) begin
         w_pix = r1_si;
      end else if (r1_edge) begin
         w_pix = w_dim;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         so_rgb <= '0;
      end else begin
         so_rgb <= w_pix;
      end
   end

endmodule
`default_nettype wire

// File: doc/tetris_board_core.md
# tetris_board_core

Video-slot core that renders the 10×20 Tetris playfield from a writable cell RAM and a 16-entry palette. It is the first colour stage in the cascading video chain: it sits directly upstream of the sprite/overlay core and feeds that core's `si_rgb` with playfield pixels over the background stream. Empty cells are transparent. Flagged rows can blink for the line-clear effect.

## Interface
- `CD`, 12, colour depth of `si_rgb`/`so_rgb`
- `KEY_COLOR`, 0, palette index treated as transparent (empty cell)
- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-low
- `x`, `y`  in  11 each  frame counter position
- `cs`, `write`  in  1 each  video slot select / write strobe
- `addr`  in  14  slot word address
- `wr_data`  in  32  slot write data
- `si_rgb`  in  CD  upstream stream pixel
- `so_rgb`  out  CD  output pixel to the next core

## Operation
- Write enable is `cs & write`. There is no read path.
- `addr[13]=0` selects the cell RAM.
  - `addr[7:0]` is the cell index, row*10+col.
  - `wr_data[3:0]` is the palette index.
  - Index ≥200 is ignored.
- `addr[13]=1` selects registers by `addr[4:0]`:
  - 0x00 `bypass` (`wr_data[0]`)
  - 0x01 `x0` (`[10:0]`)
  - 0x02 `y0` (`[10:0]`)
  - 0x03 `flash_mask` (`[19:0]`, bit r = row r)
  - 0x04 `blink_period` (`[5:0]`, frames)
  - 0x05 clear command (any data)
  - 0x10–0x1F `palette[0..15]` (`[11:0]`)
  - Other addresses are ignored.
- Geometry:
  - `rel_x = x - x0` and `rel_y = y - y0`, modulo 2^11.
  - The board is the region `x>=x0 && rel_x<160 && y>=y0 && rel_y<320`.
  - `col = rel_x[7:4]`, `row = rel_y[8:4]`, `index = (row<<3)+(row<<1)+col`.
- Pixel rules:
  - Outside the board, `so_rgb = si_rgb`.
  - Cell index == `KEY_COLOR`: `si_rgb`.
  - Row flashing and blink phase = 1: `si_rgb`.
  - Cell edge (`rel_x[3:0]` or `rel_y[3:0]` equal to 0 or 15): each 4-bit channel of `palette[idx]` shifted right 1.
  - Otherwise: `palette[idx]`.
- `bypass=1` forces `so_rgb` to the delayed `si_rgb`.
- Clear FSM:
  - States are IDLE and CLEAR.
  - Entered on reset or on a clear command.
  - CLEAR writes 0 to cells 0..199, one per cycle, using an 8-bit counter, then returns to IDLE.
  - Slot writes to cell RAM during CLEAR are dropped. Register writes are still accepted.
  - A clear command during CLEAR restarts the counter at 0.
- Blink:
  - The frame tick is a registered pulse on `x==0 && y==0`.
  - The frame counter counts ticks up to `blink_period-1`, then wraps and toggles the phase.
  - `blink_period=0` holds the phase at 0.
  - Writing `blink_period` resets the counter and the phase.

## Timing
- Reset values:
  - `so_rgb=0`, `bypass=0`, `x0=0`, `y0=0`, `flash_mask=0`, `blink_period=0`, phase 0.
  - Palette is all 0.
  - FSM is in CLEAR with counter 0.
- Fixed latency is 2 cycles: `x`/`y`/`si_rgb` sampled at edge t appear on `so_rgb` after edge t+2.
- Pipeline stages:
  - Stage 1 registers the geometry flags and index, and issues the RAM read.
  - Stage 2 does the synchronous RAM data, palette lookup and mux, and registers `so_rgb`.
  - `si_rgb` runs through a 2-register delay.
- Register and RAM writes take effect on the next edge. A pixel addressed in the same cycle as its write may show the old value.
- The clear completes 200 cycles after entry. The first accepted RAM write is in cycle 201.

## Configuration
- `TETRIS_BOARD_FLASH_EN`, when defined:
  - Builds `flash_mask`, `blink_period`, the frame counter and the phase logic.
- When undefined:
  - Writes to 0x03/0x04 are ignored.
  - No row is ever hidden.
  - The frame-tick logic is removed.

## Structure
- Package `tetris_pkg`:
  - `BOARD_COLS=10`, `BOARD_ROWS=20`, `CELL_PX=16`, `NUM_CELLS=200`
  - Register offset constants
  - Clear-FSM state enum
- Sub-module `tetris_cell_ram`: 200×4, one write port, synchronous read, no reset.

## Test plan
- Reset sequence:
  - Hold `reset=0` 2 cycles with `si_rgb=0xABC`. `so_rgb=0` during reset, then `0xABC` 2 cycles after release.
  - A cell write at cycle 50 is dropped. Cell 0 reads back 0 after 200 cycles.
- Cell rendering:
  - After the clear: `palette[3]=0xF00`, cell 0=3, `x0=100`, `y0=50`.
  - (105,55) gives `0xF00` after 2 cycles.
  - (100,55) gives `0x700`.
  - (99,55) passes `si_rgb`.
- Last cell and out-of-range write:
  - cell 199=5, `palette[5]=0x0F0`. (x0+152, y0+312) gives `0x0F0`.
  - A write to index 200 leaves all cells unchanged.
- Flash (macro on):
  - cell 0=3, `flash_mask=1`, `blink_period=2`.
  - Row 0 is visible for frames 0–1 and shows `si_rgb` for frames 2–3.
  - Row 1 is unaffected.
- Bypass: `bypass=1` over a filled board gives `so_rgb` = `si_rgb` delayed 2 cycles at every pixel.
- Mid-clear restart:
  - Issue a clear; at cycle 100 issue another.
  - Cells are all 0 exactly 200 cycles after the second command.
  - A RAM write at 250 is dropped; one at 301 is accepted.
